// File: rtl/multimac_pkg.sv
// Shared definitions for the multi-lane MAC engine.
//   state_t   : controller states (IDLE, ACCUM, DRAIN)
//   CALC_W    : width of the internal add/compare datapath used by sat_add
//   ACC_W_MAX : widest accumulator that fits CALC_W with headroom for the carry
//   acc_smax / acc_smin / acc_umax : saturation rails for an accumulator of width w
//   sat_add   : add two CALC_W-extended values and clamp to the rails of width w
package multimac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned CALC_W    = 64;
  localparam int unsigned ACC_W_MAX = 62;

  function automatic logic [CALC_W-1:0] acc_smax(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Two's-complement -2^(w-1) in CALC_W bits is the bitwise inverse of 2^(w-1)-1.
  function automatic logic [CALC_W-1:0] acc_smin(input int unsigned w);
    return ~acc_smax(w);
  endfunction

  function automatic logic [CALC_W-1:0] acc_umax(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // acc and prod arrive already sign- or zero-extended to CALC_W, so their sum
  // cannot wrap CALC_W while w <= ACC_W_MAX. Returns {sat, clamped_sum}.
  function automatic logic [CALC_W:0] sat_add(input logic [CALC_W-1:0] acc,
                                               input logic [CALC_W-1:0] prod,
                                               input logic              signed_mode,
                                               input int unsigned       w);
    logic [CALC_W-1:0] sum;
    sum = acc + prod;
    if (signed_mode) begin
      if ($signed(sum) > $signed(acc_smax(w))) return {1'b1, acc_smax(w)};
      if ($signed(sum) < $signed(acc_smin(w))) return {1'b1, acc_smin(w)};
    end else begin
      // Both operands are non-negative, so only the upper rail can be crossed.
      if (sum > acc_umax(w)) return {1'b1, acc_umax(w)};
    end
    return {1'b0, sum};
  endfunction

endpackage

// File: rtl/multimac_lane.sv
// One MAC lane: a saturating accumulator plus its sticky saturation flag.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : zero the accumulator and flag (job start)
//   en          : apply one beat acc += a*b
//   signed_mode : 1 = two's-complement operands and signed rails
//   a, b        : DATA_W operands
//   acc         : ACC_W accumulator
//   sat         : set when any beat clamped since the last clear
module multimac_lane
  import multimac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              sat
);

  logic [2*DATA_W-1:0] a_x;
  logic [2*DATA_W-1:0] b_x;
  logic [2*DATA_W-1:0] prod;
  logic [CALC_W-1:0]   prod_x;
  logic [CALC_W-1:0]   acc_x;
  logic [CALC_W:0]     add_res;

  // The low 2*DATA_W bits of a product of properly extended operands are the
  // exact signed or unsigned product, so one multiplier serves both modes.
  always_comb begin
    a_x = signed_mode ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    b_x = signed_mode ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    prod = a_x * b_x;
    prod_x = signed_mode ? {{(CALC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod}
                         : {{(CALC_W-2*DATA_W){1'b0}}, prod};
    acc_x  = signed_mode ? {{(CALC_W-ACC_W){acc[ACC_W-1]}}, acc}
                         : {{(CALC_W-ACC_W){1'b0}}, acc};
    add_res = sat_add(acc_x, prod_x, signed_mode, ACC_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= add_res[ACC_W-1:0];
      if (add_res[CALC_W]) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/multimac_lane_array.sv
// N-lane multiply-accumulate engine. Each accepted beat broadcasts in_b to all
// lanes (acc[i] += in_a[i]*in_b, saturating); after len beats the accumulators
// are drained one lane per word.
//   clk, rst          : clock, synchronous active-high reset
//   ena               : global enable; low freezes all state and blocks handshakes
//   start, len,
//   signed_mode       : job request, sampled in IDLE only
//   in_valid/in_ready : operand beat handshake (in_a lanes packed, in_b broadcast)
//   out_valid/out_ready : drain handshake carrying out_data/out_lane/out_last
//   busy              : controller not idle
//   sat_flags         : sticky per-lane saturation, cleared on start
//   state_dbg         : current controller state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. ready/valid from this block are pure functions of the registered state
// and ena; the drain payload only changes after a completed transfer.
module multimac_lane_array
  import multimac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    start,
  input  logic [CNT_W-1:0]        len,
  input  logic                    signed_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0]       in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic [LANE_W-1:0]       out_lane,
  output logic                    out_last,
  output logic                    busy,
  output logic [LANES-1:0]        sat_flags,
  output logic [1:0]              state_dbg
);

  if (ACC_W < 2*DATA_W) begin : g_bad_acc_w
    $error("multimac_lane_array: ACC_W must be >= 2*DATA_W");
  end
  if (ACC_W > int'(ACC_W_MAX)) begin : g_wide_acc_w
    $error("multimac_lane_array: ACC_W exceeds the internal datapath");
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("multimac_lane_array: LANES must be >= 1");
  end

  state_t              state;
  logic [CNT_W-1:0]    remaining;
  logic [LANE_W-1:0]   lane_idx;
  logic                mode_q;
  logic                job_start;
  logic                in_fire;
  logic                last_lane;
  logic [ACC_W-1:0]    acc_arr [LANES];
  logic [LANES-1:0]    sat_arr;

  assign in_ready  = ena && (state == ACCUM);
  assign out_valid = ena && (state == DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign job_start = ena && (state == IDLE) && start;
  assign last_lane = (lane_idx == LANE_W'(LANES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      lane_idx  <= '0;
      mode_q    <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            mode_q    <= signed_mode;
            lane_idx  <= '0;
            state     <= (len == '0) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              lane_idx <= '0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_lane) begin
              lane_idx <= '0;
              state    <= IDLE;
            end else begin
              lane_idx <= lane_idx + LANE_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    multimac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .clear       (job_start),
      .en          (in_fire),
      .signed_mode (mode_q),
      .a           (in_a[i*DATA_W +: DATA_W]),
      .b           (in_b),
      .acc         (acc_arr[i]),
      .sat         (sat_arr[i])
    );
  end

  // Payload is qualified by state only (not ena) so it stays steady while
  // ena pauses a pending drain word.
  assign out_data  = (state == DRAIN) ? acc_arr[lane_idx] : '0;
  assign out_lane  = lane_idx;
  assign out_last  = (state == DRAIN) && last_lane;
  assign busy      = (state != IDLE);
  assign sat_flags = sat_arr;
  assign state_dbg = state;

endmodule
